video_out_stage: RTL and testbench
==================================

Name: video_out_stage

Overview:
- Parametrised video output conditioner between a core's native RGB/blank/sync outputs and the 8-bit-per-channel VGA_* bus of the emu top level.
- Replaces the ad-hoc combinational bit-replication and DE assignment with a registered, ce_pix-qualified pipeline.
- Adds optional scanline darkening and per-frame measurement of the active area (width/height) for OSD and debug use.

Parameters:
RW, 5, input red width (1..OW+4)
GW, 6, input green width (1..OW+4)
BW, 5, input blue width (1..OW+4)
OW, 8, output width per channel
CW, 12, width of active-area counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
ce_pix  in  1  pixel enable strobe
red  in  RW  core red
green  in  GW  core green
blue  in  BW  core blue
hblank  in  1  horizontal blank, active high
vblank  in  1  vertical blank, active high
hsync  in  1  horizontal sync, active high
vsync  in  1  vertical sync, active high
sl_mode  in  2  scanline mode: 0 off, 1 75%, 2 50%, 3 25%
vga_r  out  OW  expanded red
vga_g  out  OW  expanded green
vga_b  out  OW  expanded blue
vga_hs  out  1  delayed hsync
vga_vs  out  1  delayed vsync
vga_de  out  1  delayed ~(hblank|vblank)
ce_out  out  1  ce_pix delayed one clk
h_active  out  CW  active pixels per line, last frame
v_active  out  CW  active lines, last frame
frame_toggle  out  1  flips once per frame at vsync rise

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: reset==0 sampled at the clk edge clears all state.
- Reset values:
  - vga_r/g/b, vga_hs, vga_vs, vga_de, ce_out = 0.
  - h_active, v_active = 0; frame_toggle = 0.
  - Internal counters, line_odd and edge-history registers = 0.
- ce_out <= ce_pix every clk. All other state advances only on clk edges where ce_pix==1; with ce_pix==0, every output except ce_out holds.
- Stage 1 (ce_pix):
  - Register sync, blank and de = ~(hblank|vblank).
  - Expand each channel to OW bits by MSB-first replication: concatenate the value with itself until the result is at least OW bits, then take the top OW bits. If input width >= OW, take the top OW bits.
  - Examples: 5->8 = {c,c[4:2]}; 6->8 = {c,c[5:4]}; 1->8 = all bits equal to c.
- Stage 2 (ce_pix):
  - Apply scanline darkening only when line_odd==1 and sl_mode!=0. Mode 1: v - (v>>2). Mode 2: v>>1. Mode 3: v>>2. Unsigned, no overflow possible.
  - Register results to vga_r/g/b.
  - Forward stage-1 sync/de to vga_hs/vs/de, so all signals stay aligned.
- Latency: exactly 2 ce_pix strobes from input to output for colour, sync and de.
- Edge detection: on stage-1 registered signals vs. their previous ce_pix sample.
- line_odd:
  - Toggles on each hsync rising edge.
  - Cleared to 0 on a vsync rising edge.
  - Simultaneous hsync and vsync rising: vsync wins, line_odd = 0.
- Measurement:
  - pix_cnt increments on each ce_pix with de==1, saturating at 2^CW-1.
  - On the de falling edge with pix_cnt!=0: latch last_w <= pix_cnt; line_cnt increments (saturating); pix_cnt clears.
  - On vsync rising edge: h_active <= last_w; v_active <= line_cnt; frame_toggle flips; line_cnt, pix_cnt and last_w clear.
  - A de falling edge coinciding with vsync rise: counts into that frame first (use the incremented line_cnt and updated last_w), then publish.
- Reset asserted mid-frame: discards partial measurement. The first vsync after reset release publishes only lines seen since release.
- sl_mode changes take effect on the next ce_pix with no glitch; the value is sampled in stage 2.

Test Plan:
- Reset low 3 clks with random inputs -> all outputs 0; after release with ce_pix=0 constant, all outputs except ce_out stay 0.
- RW=5, red=5'b10110, ce_pix every clk -> vga_r=8'b10110101 after 2 strobes; GW=6, green=6'h3F -> vga_g=8'hFF; green=0 -> 8'h00.
- ce_pix every 4th clk, de/hsync pulses -> output transitions only on strobe edges, exactly 2 strobes late; ce_out follows ce_pix by 1 clk.
- sl_mode=2, white input over 4 lines after a vsync -> lines 0,2 output 8'hFF, lines 1,3 output 8'h7F; sl_mode=1 -> odd lines 8'hC0; sl_mode=3 -> 8'h3F.
- Frame of 240 lines x 320 de pixels, then vsync rise -> h_active=320, v_active=240, frame_toggle flips once; next frame 200x256 -> 256/200.
- CW=8, line of 300 de pixels -> h_active saturates at 255; hsync and vsync rising on same strobe -> line_odd=0.

Source files
------------

// File: rtl/video_out_stage.sv
// Video output conditioner: ce_pix-qualified two-stage pipeline from native core RGB/sync
// to the 8-bit VGA bus, with scanline darkening and per-frame active-area measurement.
module video_out_stage #(
    parameter int RW = 5,
    parameter int GW = 6,
    parameter int BW = 5,
    parameter int OW = 8,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [RW-1:0] red,
    input  logic [GW-1:0] green,
    input  logic [BW-1:0] blue,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [1:0]    sl_mode,
    output logic [OW-1:0] vga_r,
    output logic [OW-1:0] vga_g,
    output logic [OW-1:0] vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          ce_out,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic          frame_toggle
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [OW-1:0] r_exp, g_exp, b_exp;
    logic [OW-1:0] s1_r, s1_g, s1_b;
    logic          s1_hs, s1_vs, s1_de;
    logic          p_hs, p_vs, p_de;
    logic          line_odd;
    logic [CW-1:0] pix_cnt, line_cnt, last_w;

    logic          hs_rise, vs_rise, de_fall;
    logic [1:0]    sl_sel;
    logic          odd_next, tog_next;
    logic [CW-1:0] pix_next, line_next, w_next, h_next, v_next;

    // MSB-first replication; output bit k (from the top) takes input bit k mod width (from the top).
    for (genvar i = 0; i < OW; i++) begin : g_expand
        assign r_exp[OW-1-i] = red[RW-1-(i % RW)];
        assign g_exp[OW-1-i] = green[GW-1-(i % GW)];
        assign b_exp[OW-1-i] = blue[BW-1-(i % BW)];
    end

    function automatic logic [OW-1:0] dim(input logic [OW-1:0] v, input logic [1:0] mode);
        case (mode)
            2'd1:    dim = v - (v >> 2);
            2'd2:    dim = v >> 1;
            2'd3:    dim = v >> 2;
            default: dim = v;
        endcase
    endfunction

    assign hs_rise = s1_hs & ~p_hs;
    assign vs_rise = s1_vs & ~p_vs;
    assign de_fall = p_de & ~s1_de;
    assign sl_sel  = line_odd ? sl_mode : 2'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_de  <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b0;
            vga_vs <= 1'b0;
            vga_de <= 1'b0;
            ce_out <= 1'b0;
        end else begin
            ce_out <= ce_pix;
            if (ce_pix) begin
                s1_r   <= r_exp;
                s1_g   <= g_exp;
                s1_b   <= b_exp;
                s1_hs  <= hsync;
                s1_vs  <= vsync;
                s1_de  <= ~(hblank | vblank);
                vga_r  <= dim(s1_r, sl_sel);
                vga_g  <= dim(s1_g, sl_sel);
                vga_b  <= dim(s1_b, sl_sel);
                vga_hs <= s1_hs;
                vga_vs <= s1_vs;
                vga_de <= s1_de;
            end
        end
    end

    // A de fall landing on the vsync rise is counted first, so the frame's last line is published.
    always_comb begin
        pix_next  = pix_cnt;
        line_next = line_cnt;
        w_next    = last_w;
        h_next    = h_active;
        v_next    = v_active;
        tog_next  = frame_toggle;
        odd_next  = line_odd;
        if (s1_de && pix_cnt != CNT_MAX) pix_next = pix_cnt + CNT_ONE;
        if (de_fall && pix_cnt != '0) begin
            w_next    = pix_cnt;
            pix_next  = '0;
            line_next = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_ONE;
        end
        if (hs_rise) odd_next = ~line_odd;
        if (vs_rise) begin
            h_next    = w_next;
            v_next    = line_next;
            tog_next  = ~frame_toggle;
            pix_next  = '0;
            line_next = '0;
            w_next    = '0;
            odd_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_hs         <= 1'b0;
            p_vs         <= 1'b0;
            p_de         <= 1'b0;
            line_odd     <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            last_w       <= '0;
            h_active     <= '0;
            v_active     <= '0;
            frame_toggle <= 1'b0;
        end else if (ce_pix) begin
            p_hs         <= s1_hs;
            p_vs         <= s1_vs;
            p_de         <= s1_de;
            line_odd     <= odd_next;
            pix_cnt      <= pix_next;
            line_cnt     <= line_next;
            last_w       <= w_next;
            h_active     <= h_next;
            v_active     <= v_next;
            frame_toggle <= tog_next;
        end
    end

endmodule

// File: tb/tb_video_out_stage.sv
// Directed bench for video_out_stage: expansion, latency under sparse ce_pix,
// scanline modes, active-area measurement, saturation and reset behaviour.
module tb_video_out_stage;

    logic       clk = 1'b0;
    logic       reset, ce_pix;
    logic [4:0] red, blue;
    logic [5:0] green;
    logic       hblank, vblank, hsync, vsync;
    logic [1:0] sl_mode;

    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, ce_out, frame_toggle;
    logic [11:0] h_active, v_active;

    logic [7:0]  r8, g8, b8;
    logic        hs8, vs8, de8, ce8, tog8;
    logic [7:0]  h8, v8;

    int   n_total = 0;
    int   n_bad   = 0;
    logic exp_tog;

    always #5 clk = ~clk;

    video_out_stage dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .sl_mode(sl_mode),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .ce_out(ce_out),
        .h_active(h_active), .v_active(v_active), .frame_toggle(frame_toggle)
    );

    video_out_stage #(.CW(8)) dut8 (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .sl_mode(sl_mode),
        .vga_r(r8), .vga_g(g8), .vga_b(b8),
        .vga_hs(hs8), .vga_vs(vs8), .vga_de(de8), .ce_out(ce8),
        .h_active(h8), .v_active(v8), .frame_toggle(tog8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                       input logic hb, input logic vb, input logic hs, input logic vs);
        red = r; green = g; blue = b;
        hblank = hb; vblank = vb; hsync = hs; vsync = vs;
        ce_pix = 1'b1;
        tick();
    endtask

    task automatic vs_pulse(input logic hs);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b1, hs, 1'b1);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b1, hs, 1'b1);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_tog = ~exp_tog;
    endtask

    // White active pixels; optional trailing hblank with an hsync pulse.
    task automatic send_line(input int npix, input bit tail, input bit chk, input logic [7:0] exp_c);
        for (int i = 0; i < npix; i++) begin
            pix(5'h1F, 6'h3F, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
            if (chk && i == 3) begin
                check("sl_r", vga_r, exp_c);
                check("sl_g", vga_g, exp_c);
                check("sl_de", vga_de, 1);
            end
        end
        if (tail) begin
            pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Last line has no tail, so its de fall coincides with the vsync rise.
    task automatic frame(input int lines, input int w);
        for (int l = 0; l < lines; l++) send_line(w, l != lines - 1, 1'b0, 8'h00);
        vs_pulse(1'b0);
    endtask

    task automatic scan_test(input logic [1:0] mode, input int nlines, input logic [7:0] exp_odd);
        sl_mode = mode;
        vs_pulse(1'b0);
        for (int l = 0; l < nlines; l++) send_line(8, 1'b1, 1'b1, (l % 2 == 1) ? exp_odd : 8'hFF);
    endtask

    initial begin
        reset = 1'b0; ce_pix = 1'b0; sl_mode = 2'd0; exp_tog = 1'b0;
        red = '0; green = '0; blue = '0; hblank = 1'b1; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;

        // reset with random inputs
        repeat (3) begin
            red = 5'($urandom_range(0, 31)); green = 6'($urandom_range(0, 63)); blue = 5'($urandom_range(0, 31));
            hblank = 1'($urandom_range(0, 1)); vblank = 1'($urandom_range(0, 1));
            hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
            sl_mode = 2'($urandom_range(0, 3)); ce_pix = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_r", vga_r, 0);
        check("rst_g", vga_g, 0);
        check("rst_b", vga_b, 0);
        check("rst_sync", {vga_hs, vga_vs, vga_de}, 0);
        check("rst_ce_out", ce_out, 0);
        check("rst_meas", {h_active, v_active, frame_toggle}, 0);
        check("rst8_all", {r8, g8, b8, hs8, vs8, de8, ce8, h8, v8, tog8}, 0);

        // release with ce_pix held low: nothing moves
        reset = 1'b1; ce_pix = 1'b0;
        repeat (4) begin
            red = 5'($urandom_range(0, 31)); green = 6'($urandom_range(0, 63)); blue = 5'($urandom_range(0, 31));
            hblank = 1'($urandom_range(0, 1)); hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
            tick();
        end
        check("idle_rgb", {vga_r, vga_g, vga_b}, 0);
        check("idle_sync", {vga_hs, vga_vs, vga_de, ce_out}, 0);
        check("idle_meas", {h_active, v_active, frame_toggle}, 0);

        // channel expansion
        sl_mode = 2'd0;
        pix(5'b10110, 6'h3F, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(5'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("exp_r5", vga_r, 8'hB5);
        check("exp_g6", vga_g, 8'hFF);
        check("exp_b5", vga_b, 8'h08);
        check("exp_de", vga_de, 1);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("exp_zero", {vga_r, vga_g, vga_b}, 0);

        // sparse ce_pix: one strobe every 4 clks
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        ce_pix = 1'b0; repeat (3) tick();
        pix(5'h1F, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("gap_ce_out_hi", ce_out, 1);
        ce_pix = 1'b0; tick();
        check("gap_ce_out_lo", ce_out, 0);
        check("gap_s1_hs", vga_hs, 0);
        repeat (2) tick();
        check("gap_s1_de", vga_de, 0);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_s2_hs", vga_hs, 1);
        check("gap_s2_r", vga_r, 8'hFF);
        ce_pix = 1'b0; repeat (3) tick();
        check("gap_hold_hs", vga_hs, 1);
        check("gap_hold_de", vga_de, 1);
        pix(5'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_s3_hs", vga_hs, 0);
        check("gap_s3_de", vga_de, 0);

        // scanline darkening
        scan_test(2'd2, 4, 8'h7F);
        scan_test(2'd1, 2, 8'hC0);
        scan_test(2'd3, 2, 8'h3F);

        // active-area measurement
        sl_mode = 2'd0;
        vs_pulse(1'b0);
        frame(12, 40);
        check("meas1_h", h_active, 40);
        check("meas1_v", v_active, 12);
        check("meas1_tog", frame_toggle, exp_tog);
        frame(10, 25);
        check("meas2_h", h_active, 25);
        check("meas2_v", v_active, 10);
        check("meas2_tog", frame_toggle, exp_tog);

        // saturation with CW=8
        vs_pulse(1'b0);
        send_line(300, 1'b1, 1'b0, 8'h00);
        vs_pulse(1'b0);
        check("sat8_h", h8, 8'hFF);
        check("sat8_v", v8, 1);
        check("sat12_h", h_active, 300);

        // hsync and vsync rising together: line stays even
        sl_mode = 2'd2;
        vs_pulse(1'b0);
        vs_pulse(1'b1);
        send_line(8, 1'b1, 1'b1, 8'hFF);

        // reset mid-frame discards partial counts
        sl_mode = 2'd0;
        send_line(20, 1'b1, 1'b0, 8'h00);
        send_line(20, 1'b0, 1'b0, 8'h00);
        reset = 1'b0; repeat (2) tick();
        reset = 1'b1; exp_tog = 1'b0;
        check("mid_rst_h", h_active, 0);
        check("mid_rst_tog", frame_toggle, 0);
        frame(3, 10);
        check("post_rst_h", h_active, 10);
        check("post_rst_v", v_active, 3);
        check("post_rst_tog", frame_toggle, exp_tog);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
